// File: rtl/dec_imm_pkg.sv
// Shared opcode/funct constants, encodings and stage bundles
// for the decode/immediate stage of the pipelined MIPS core.
package dec_imm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_OR    = 2'b10,
    ALU_PASSB = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } ext_mode_e;

  typedef struct packed {
    logic [4:0] wa;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    aluop_e     aluop;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    ctrl_t       ctrl;
    logic        valid;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/dec_imm_stage_main.sv
// Main instruction decoder: extender mode, control bundle,
// register-use flags and illegal-instruction flag.
module dec_main
  import dec_imm_pkg::*;
(
  input  logic [31:0] instr,
  output ext_mode_e   ext_mode,
  output ctrl_t       ctrl,
  output logic        rs_use,
  output logic        rt_use,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  logic is_r, is_addu, is_subu, is_jr;
  logic is_ori, is_lui, is_addiu, is_lw;
  logic is_sw, is_beq, is_j, is_jal;

  assign is_r     = (op == OP_RTYPE);
  assign is_addu  = is_r && (fn == FN_ADDU);
  assign is_subu  = is_r && (fn == FN_SUBU);
  assign is_jr    = is_r && (fn == FN_JR);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_addiu = (op == OP_ADDIU);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);

  // Use flags follow the opcode class, legal or not.
  assign rs_use = !(is_j || is_jal || is_lui);
  assign rt_use = is_r || is_sw || is_beq;

  always_comb begin
    ctrl     = '0;
    ext_mode = EXT_ZERO;
    illegal  = 1'b0;
    unique case (1'b1)
      is_addu: begin
        ctrl.wa       = rd;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      is_subu: begin
        ctrl.wa       = rd;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_SUB;
      end
      is_jr: begin
        ctrl.aluop = ALU_ADD;
      end
      is_ori: begin
        ctrl.wa       = rt;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_OR;
      end
      is_lui: begin
        ext_mode      = EXT_LUI;
        ctrl.wa       = rt;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_PASSB;
      end
      is_addiu: begin
        ext_mode      = EXT_SIGN;
        ctrl.wa       = rt;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      is_lw: begin
        ext_mode      = EXT_SIGN;
        ctrl.wa       = rt;
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      is_sw: begin
        ext_mode      = EXT_SIGN;
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      is_beq: begin
        ext_mode   = EXT_SIGN;
        ctrl.aluop = ALU_SUB;
      end
      is_j: begin
        ctrl.aluop = ALU_ADD;
      end
      is_jal: begin
        ctrl.wa       = 5'd31;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dec_imm_stage.sv
// Decode stage: immediate extension, load-use hazard bubble,
// D/E pipeline register and saturating stall counter.
module dec_imm_stage
  import dec_imm_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int STALL_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr_d,
  input  logic                   valid_d,
  input  logic                   flush_i,
  output logic                   stall_o,
  output logic [31:0]            imm32_e,
  output logic [4:0]             rs_e,
  output logic [4:0]             rt_e,
  output logic [4:0]             wa_e,
  output logic                   regwrite_e,
  output logic                   memread_e,
  output logic                   memwrite_e,
  output logic                   alusrc_e,
  output logic [1:0]             aluop_e,
  output logic                   valid_e,
  output logic                   illegal_e,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  ext_mode_e ext_mode;
  ctrl_t     ctrl_dec;
  logic      rs_use;
  logic      rt_use;
  logic      illegal_dec;

  dec_main u_dec (
    .instr    (instr_d),
    .ext_mode (ext_mode),
    .ctrl     (ctrl_dec),
    .rs_use   (rs_use),
    .rt_use   (rt_use),
    .illegal  (illegal_dec)
  );

  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [15:0] imm16;
  logic [31:0] imm32_d;

  assign rs_d  = instr_d[25:21];
  assign rt_d  = instr_d[20:16];
  assign imm16 = instr_d[15:0];

  always_comb begin
    imm32_d = {16'h0000, imm16};
    case (ext_mode)
      EXT_SIGN: imm32_d = {{16{imm16[15]}}, imm16};
      EXT_LUI:  imm32_d = {imm16, 16'h0000};
      default:  imm32_d = {16'h0000, imm16};
    endcase
  end

  id_ex_t                 e_q;
  id_ex_t                 e_d;
  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;

  logic hit_rs;
  logic hit_rt;

  assign hit_rs = rs_use && (rs_d == e_q.rt);
  assign hit_rt = rt_use && (rt_d == e_q.rt);

  // Only a load still in E can create a hazard; the bubble clears it.
  assign stall_o = (LOAD_USE_STALL != 0)
                && e_q.valid
                && e_q.ctrl.memread
                && (e_q.rt != 5'd0)
                && valid_d
                && (hit_rs || hit_rt);

  always_comb begin
    e_d   = '0;
    cnt_d = cnt_q;
    if (!(flush_i || stall_o || !valid_d)) begin
      e_d.imm32   = imm32_d;
      e_d.rs      = rs_d;
      e_d.rt      = rt_d;
      e_d.ctrl    = ctrl_dec;
      e_d.valid   = 1'b1;
      e_d.illegal = illegal_dec;
    end
    if (stall_o && !flush_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end

  assign imm32_e    = e_q.imm32;
  assign rs_e       = e_q.rs;
  assign rt_e       = e_q.rt;
  assign wa_e       = e_q.ctrl.wa;
  assign regwrite_e = e_q.ctrl.regwrite;
  assign memread_e  = e_q.ctrl.memread;
  assign memwrite_e = e_q.ctrl.memwrite;
  assign alusrc_e   = e_q.ctrl.alusrc;
  assign aluop_e    = e_q.ctrl.aluop;
  assign valid_e    = e_q.valid;
  assign illegal_e  = e_q.illegal;
  assign stall_cnt  = cnt_q;

endmodule

// File: doc/dec_imm_stage.md
Name: dec_imm_stage

Overview:
Decode-stage sequencer for the pipelined MIPS core. It decodes the D-stage instruction, sets the immediate extender's mode (zero, sign or lui-shift), and registers the extended immediate and control bundle into the D/E pipeline register. It also detects load-use hazards against its own E-stage copy and inserts bubbles, and it counts stall cycles.

Parameters:
LOAD_USE_STALL, 1, 1 enables load-use hazard detection; 0 forces stall_o=0.
STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
instr_d  in  32  D-stage instruction word
valid_d  in  1  instr_d holds a real instruction
flush_i  in  1  kill the D-stage instruction; load a bubble into E
stall_o  out  1  load-use stall; upstream holds PC and F/D
imm32_e  out  32  extended immediate, E stage
rs_e, rt_e, wa_e  out  5 each  source regs / write address, E stage
regwrite_e, memread_e, memwrite_e, alusrc_e  out  1 each  control, E stage
aluop_e  out  2  00 add, 01 sub, 10 or, 11 pass-B
valid_e  out  1  E holds a real instruction
illegal_e  out  1  E instruction is undecodable
stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset (synchronous): all *_e outputs and stall_cnt go to 0, which is equivalent to a bubble.
- Extender mode:
  - lui (0x0F) selects the shift: {imm16,16'h0}.
  - addiu (0x09), lw (0x23), sw (0x2B) and beq (0x04) select sign extension.
  - ori (0x0D) and all other opcodes select zero extension.
- Decode:
  - R-type addu (funct 0x21) and subu (0x23): wa=rd, regwrite=1.
  - jr (0x08): reads rs, writes nothing.
  - ori, lui, addiu: wa=rt, regwrite=1, alusrc=1.
  - lw: also sets memread.
  - sw: memwrite=1, alusrc=1.
  - jal (0x03): wa=31, regwrite=1.
  - j (0x02) and beq: no write.
  - Any other opcode or funct: all enables 0 and illegal=1.
- Register-use:
  - rs is used by everything except j, jal and lui.
  - rt is used by R-type, sw and beq.
- stall_o is combinational from registered E state plus instr_d. It is 1 when LOAD_USE_STALL=1, valid_e, memread_e, rt_e!=0 and valid_d all hold, and either (rs used and rs_d==rt_e) or (rt used and rt_d==rt_e).
- D/E register update priority each edge: reset > flush_i > stall_o > !valid_d > normal.
  - flush_i or stall_o: load a bubble (all controls 0, valid_e=0, illegal_e=0).
  - !valid_d: load a bubble.
  - normal: load the decoded bundle with valid_e=1.
- Latency: one cycle from instr_d to the *_e outputs.
- A stall lasts exactly 1 cycle: after the bubble, memread_e=0, so the condition clears.
- stall_cnt increments on every edge where stall_o=1 and flush_i=0. It saturates at all-ones and never wraps.
- Simultaneous flush_i and stall_o: flush wins and the counter does not increment.
- Reset asserted mid-stall: the bubble state is restored, stall_o falls the following cycle, and stall_cnt is cleared.
- imm32_e is registered even for instructions that do not use it; its value is don't-care only when valid_e=0.

Decomposition:
- Shared `include header holds:
  - opcode and funct constants: OP_RTYPE, OP_ORI, OP_LUI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, FN_ADDU, FN_SUBU, FN_JR;
  - ALUOP encodings;
  - extender mode encodings.
- One combinational sub-module, dec_main: instr in; ext mode, control bundle, rs/rt-use flags and illegal out.
- The top level holds the extender logic, the hazard compare, the D/E register and the counter.

Test Plan:
- lui $1,0x1234 (0x3C011234) -> next cycle: imm32_e=0x12340000, wa_e=1, regwrite_e=1, alusrc_e=1, aluop_e=11.
- ori $2,$0,0x8000 (0x34028000) -> imm32_e=0x00008000. Then addiu $3,$0,-4 (0x2403FFFC) -> imm32_e=0xFFFFFFFC.
- lw $4,0($0) (0x8C040000) then addu $5,$4,$4 (0x00842821):
  - stall_o=1 for exactly 1 cycle, followed by a bubble (valid_e=0);
  - then addu with wa_e=5;
  - stall_cnt=1.
- lw $0,0($0) then addu $5,$0,$0 -> no stall.
- sw $4,0($0) after lw $4 -> stall, because rt is used.
- flush_i asserted in the same cycle as a load-use stall -> valid_e=0, stall_cnt unchanged. An undefined opcode 0x3F -> illegal_e=1, all enables 0.
- Reset asserted mid-stream with stall_o=1 -> after one edge all outputs are 0. Also: drive 2^STALL_CNT_W+3 stalls with STALL_CNT_W=4 -> stall_cnt holds at 15.
